// File: rtl/eeg_epoch_ingest_pkg.sv
// Shared definitions for the EEG epoch ingest path: int-res word/address types,
// epoch geometry and the ingest FSM state encoding.
package eeg_epoch_ingest_pkg;

    localparam int INT_RES_ADDR_W = 16;
    localparam int INT_RES_DATA_W = 16;

    typedef logic        [INT_RES_ADDR_W-1:0] IntResAddr_t;
    typedef logic signed [INT_RES_DATA_W-1:0] IntRes_t;

    localparam int          EEG_EPOCH_LEN = 3000;
    localparam IntResAddr_t EEG_BASE_ADDR = 16'h1000;

    typedef enum logic [1:0] {
        IDLE_INGEST = 2'd0,
        FILL        = 2'd1,
        HANDOFF     = 2'd2,
        WAIT_CIM    = 2'd3
    } IngestState_t;

endpackage

// File: rtl/eeg_sample_conv.sv
// Raw unsigned ADC code to signed fixed-point: midscale removal, arithmetic
// right shift, truncation to the int-res word width. Purely combinational.
module eeg_sample_conv #(
    parameter int IN_W   = 16,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 2
) (
    input  logic [IN_W-1:0]   i_raw,
    output logic [DATA_W-1:0] o_conv
);

    localparam logic signed [IN_W:0] MIDSCALE = {2'b01, {(IN_W-1){1'b0}}};

    logic signed [IN_W:0] w_centered;
    logic signed [IN_W:0] w_shifted;

    assign w_centered = $signed({1'b0, i_raw}) - MIDSCALE;
    assign w_shifted  = w_centered >>> SHIFT;
    assign o_conv     = DATA_W'(w_shifted);

endmodule

// File: rtl/eeg_epoch_ingest.sv
// Buffers one EEG epoch of converted ADC samples into int-res memory and hands it
// to the CIM. Optional dropped-sample counter enabled by EEG_INGEST_DROP_CNT_EN.
//
//   state       | meaning
//   IDLE_INGEST | disabled, samples ignored
//   FILL        | writing samples at EEG_BASE_ADDR + idx
//   HANDOFF     | epoch complete, new_sleep_epoch being issued
//   WAIT_CIM    | CIM owns the buffer until inference_done
module eeg_epoch_ingest
    import eeg_epoch_ingest_pkg::*;
#(
    parameter int EPOCH_LEN = EEG_EPOCH_LEN,
    parameter int ADDR_W    = INT_RES_ADDR_W,
    parameter int DATA_W    = INT_RES_DATA_W,
    parameter int IN_SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_sample_valid,
    input  logic [15:0]       i_sample_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic              o_new_sleep_epoch,
    input  logic              i_inference_done,
    output logic              o_busy
`ifdef EEG_INGEST_DROP_CNT_EN
    ,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int IDX_W = $clog2(EPOCH_LEN);

    IngestState_t      r_state;
    IngestState_t      w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_new_epoch;

    logic              w_accept;
    logic              w_idx_clr;
    logic              w_handoff;
    logic              w_drop;
    logic              w_last;
    logic [DATA_W-1:0] w_conv;

    eeg_sample_conv #(
        .IN_W   (16),
        .DATA_W (DATA_W),
        .SHIFT  (IN_SHIFT)
    ) u_conv (
        .i_raw  (i_sample_data),
        .o_conv (w_conv)
    );

    assign w_last = (r_idx == IDX_W'(EPOCH_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE_INGEST;
        else        r_state <= w_state_nxt;
    end

    // w_drop marks samples lost while the block is enabled or holding the buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_idx_clr   = 1'b0;
        w_handoff   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE_INGEST: begin
                w_idx_clr = 1'b1;
                w_drop    = i_en & i_sample_valid;
                if (i_en) w_state_nxt = FILL;
            end
            FILL: begin
                if (!i_en) begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = IDLE_INGEST;
                end else if (i_sample_valid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_idx_clr   = 1'b1;
                        w_state_nxt = HANDOFF;
                    end
                end
            end
            HANDOFF: begin
                w_handoff   = 1'b1;
                w_drop      = i_sample_valid;
                w_state_nxt = WAIT_CIM;
            end
            WAIT_CIM: begin
                w_drop = i_sample_valid;
                if (i_inference_done) begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = i_en ? FILL : IDLE_INGEST;
                end
            end
            default: begin
                w_idx_clr   = 1'b1;
                w_state_nxt = IDLE_INGEST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         r_idx <= '0;
        else if (w_idx_clr) r_idx <= '0;
        else if (w_accept)  r_idx <= r_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_new_epoch <= 1'b0;
        end else begin
            r_wr_en     <= w_accept;
            r_new_epoch <= w_handoff;
            if (w_accept) begin
                r_wr_addr <= ADDR_W'(EEG_BASE_ADDR) + ADDR_W'(r_idx);
                r_wr_data <= w_conv;
            end
        end
    end

`ifdef EEG_INGEST_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Clear coincides with the pulse being issued; a drop in that same cycle counts once.
    always_ff @(posedge clk) begin
        if (!rst_n)                         r_drop_cnt <= '0;
        else if (w_handoff)                 r_drop_cnt <= {15'd0, w_drop};
        else if (w_drop && !(&r_drop_cnt))  r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_mem_wr_en       = r_wr_en;
    assign o_mem_wr_addr     = r_wr_addr;
    assign o_mem_wr_data     = r_wr_data;
    assign o_new_sleep_epoch = r_new_epoch;
    assign o_busy            = (r_state == HANDOFF) || (r_state == WAIT_CIM);

endmodule

// File: tb/tb_eeg_epoch_ingest.sv
// Directed bench for eeg_epoch_ingest: expected writes are queued as samples are
// driven and checked against the write port by a monitor.
module tb_eeg_epoch_ingest;
    import eeg_epoch_ingest_pkg::*;

    localparam int          LEN  = 3000;
    localparam logic [15:0] BASE = EEG_BASE_ADDR;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        new_sleep_epoch;
    logic        inference_done;
    logic        busy;
`ifdef EEG_INGEST_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    eeg_epoch_ingest dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_en              (en),
        .i_sample_valid    (sample_valid),
        .i_sample_data     (sample_data),
        .o_mem_wr_en       (mem_wr_en),
        .o_mem_wr_addr     (mem_wr_addr),
        .o_mem_wr_data     (mem_wr_data),
        .o_new_sleep_epoch (new_sleep_epoch),
        .i_inference_done  (inference_done),
        .o_busy            (busy)
`ifdef EEG_INGEST_DROP_CNT_EN
        ,
        .o_drop_cnt        (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  n_pulse = 0;

    function automatic logic [15:0] conv(input logic [15:0] d);
        int s;
        s = int'(d) - 32768;
        s = s >>> 2;
        return s[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic e,
                        input bit exp_wr, input int idx);
        wr_t w;
        @(negedge clk);
        sample_valid = v;
        sample_data  = d;
        en           = e;
        if (exp_wr) begin
            w.addr = BASE + 16'(idx);
            w.data = conv(d);
            q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            check("wr_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                wr_t w;
                w = q.pop_front();
                check("wr_addr", 32'(mem_wr_addr), 32'(w.addr));
                check("wr_data", 32'(mem_wr_data), 32'(w.data));
            end
        end
        if (new_sleep_epoch === 1'b1) n_pulse++;
    end

    initial begin
        rst_n          = 1'b0;
        en             = 1'b0;
        sample_valid   = 1'b0;
        sample_data    = '0;
        inference_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr",  32'(mem_wr_addr), 32'd0);
        check("rst_data",  32'(mem_wr_data), 32'd0);
        check("rst_nse",   32'(new_sleep_epoch), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
`ifdef EEG_INGEST_DROP_CNT_EN
        check("rst_drop",  32'(drop_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1, 0, 0);

        // full epoch of ramp samples
        for (int i = 0; i < LEN; i++) step(1'b1, 16'h8000 + 16'(i), 1'b1, 1, i);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t1_busy_handoff", 32'(busy), 32'd1);
        check("t1_nse_early",    32'(new_sleep_epoch), 32'd0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t1_nse_pulse",    32'(new_sleep_epoch), 32'd1);
        check("t1_busy_wait",    32'(busy), 32'd1);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t1_nse_single",   32'(new_sleep_epoch), 32'd0);
        check("t1_q_empty",      32'(q.size()), 32'd0);
        check("t1_pulses",       32'(n_pulse), 32'd1);

        // samples while the CIM holds the buffer are dropped
        for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom), 1'b1, 0, 0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t3_busy", 32'(busy), 32'd1);
`ifdef EEG_INGEST_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 32'd10);
`endif
        @(negedge clk); inference_done = 1'b1;
        @(negedge clk); inference_done = 1'b0;
        check("t3_busy_released", 32'(busy), 32'd0);

        // conversion corner codes, starting again at BASE
        step(1'b1, 16'h0000, 1'b1, 1, 0);
        step(1'b1, 16'hFFFF, 1'b1, 1, 1);
        check("t2_addr_base", 32'(mem_wr_addr), 32'(BASE));
        check("t2_d_0000", 32'(mem_wr_data), 32'h0000_E000);
        step(1'b1, 16'h8000, 1'b1, 1, 2);
        check("t2_d_ffff", 32'(mem_wr_data), 32'h0000_1FFF);
        step(1'b1, 16'h8003, 1'b1, 1, 3);
        check("t2_d_8000", 32'(mem_wr_data), 32'h0000_0000);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t2_d_8003", 32'(mem_wr_data), 32'h0000_0000);

        // abort mid-epoch, then partial epoch and abort again
        step(1'b0, 16'h0, 1'b0, 0, 0);
        step(1'b0, 16'h0, 1'b0, 0, 0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        for (int i = 0; i < LEN / 2; i++) step(1'b1, 16'(i * 7), 1'b1, 1, i);
        step(1'b1, 16'h4321, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 0, 0);
        check("t4_abort_pulses", 32'(n_pulse), 32'd1);
        check("t4_abort_busy",   32'(busy), 32'd0);
        check("t4_abort_q",      32'(q.size()), 32'd0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        for (int i = 0; i < LEN; i++) step(1'b1, 16'($urandom), 1'b1, 1, i);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t4_nse_early", 32'(new_sleep_epoch), 32'd0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t4_nse_pulse", 32'(new_sleep_epoch), 32'd1);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t4_pulses", 32'(n_pulse), 32'd2);

        // sample coincident with inference_done is dropped
        @(negedge clk);
        inference_done = 1'b1;
        sample_valid   = 1'b1;
        sample_data    = 16'h1234;
        @(negedge clk);
        inference_done = 1'b0;
        sample_valid   = 1'b0;
        check("t5_no_write", 32'(mem_wr_en), 32'd0);
        check("t5_busy",     32'(busy), 32'd0);
        step(1'b1, 16'h9000, 1'b1, 1, 0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t5_addr_base", 32'(mem_wr_addr), 32'(BASE));

        // reset during FILL with a sample present
        step(1'b1, 16'hA000, 1'b1, 1, 1);
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 16'hB000;
        @(negedge clk);
        check("t6_wr_en", 32'(mem_wr_en), 32'd0);
        check("t6_addr",  32'(mem_wr_addr), 32'd0);
        check("t6_data",  32'(mem_wr_data), 32'd0);
        check("t6_busy",  32'(busy), 32'd0);
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        step(1'b0, 16'h0, 1'b1, 0, 0);
        step(1'b1, 16'hC000, 1'b1, 1, 0);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("t6_restart_addr", 32'(mem_wr_addr), 32'(BASE));
        check("t6_restart_data", 32'(mem_wr_data), 32'h0000_1000);
        step(1'b0, 16'h0, 1'b1, 0, 0);
        check("end_q_empty", 32'(q.size()), 32'd0);
        check("end_pulses",  32'(n_pulse), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
